// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: owner encoding, dmem
// size selects and the packed memory command carried through the port mux.
package dmem_arb_pkg;

    typedef enum logic {
        S_CPU = 1'b0,
        S_DMA = 1'b1
    } owner_e;

    localparam logic [1:0] CS_WORD = 2'b00;
    localparam logic [1:0] CS_HALF = 2'b01;
    localparam logic [1:0] CS_BYTE = 2'b10;

    typedef struct packed {
        logic        ena;
        logic        wena;
        logic [1:0]  w_cs;
        logic [1:0]  r_cs;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_cmd_t;

    localparam int CMD_W = $bits(dmem_cmd_t);

    // A master that is not granted presents an idle command (no enable, no write).
    function automatic dmem_cmd_t make_cmd(input logic        gnt,
                                           input logic        we,
                                           input logic [1:0]  w_cs,
                                           input logic [1:0]  r_cs,
                                           input logic [31:0] addr,
                                           input logic [31:0] wdata);
        dmem_cmd_t cmd;
        cmd.ena   = gnt;
        cmd.wena  = gnt & we;
        cmd.w_cs  = w_cs;
        cmd.r_cs  = r_cs;
        cmd.addr  = addr;
        cmd.wdata = wdata;
        return cmd;
    endfunction

endpackage

// File: rtl/dmem_arb_cmd_mux.sv
// 2:1 selector placing the granted master's command on the dmem port.
module dmem_arb_cmd_mux
    import dmem_arb_pkg::*;
(
    input  logic             sel_dma,
    input  logic [CMD_W-1:0] cpu_cmd,
    input  logic [CMD_W-1:0] dma_cmd,
    output logic [CMD_W-1:0] mem_cmd
);

    // Port command selection.
    always_comb begin
        mem_cmd = cpu_cmd;
        if (sel_dma) begin
            mem_cmd = dma_cmd;
        end else begin
            mem_cmd = cpu_cmd;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single dmem port between the CPU MEM stage and a DMA master.
// Optional build macro DMEM_ARB_STATS_EN adds DMA-grant / CPU-stall counters.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_w_cs,
    input  logic [1:0]  cpu_r_cs,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_lock,
    input  logic        dma_we,
    input  logic [1:0]  dma_w_cs,
    input  logic [1:0]  dma_r_cs,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    output logic        mem_ena,
    output logic        mem_wena,
    output logic [1:0]  mem_w_cs,
    output logic [1:0]  mem_r_cs,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0] stat_dma_grants,
    output logic [31:0] stat_cpu_stalls
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT);
    localparam logic [LW-1:0] LOCK_TOP   = LW'(LOCK_MAX);

    owner_e          owner_r;
    owner_e          owner_nxt_s;
    logic [SW-1:0]   starve_cnt_r;
    logic [SW-1:0]   starve_nxt_s;
    logic [LW-1:0]   lock_cnt_r;
    logic [LW-1:0]   lock_nxt_s;
    logic            dma_gnt_s;
    logic            cpu_gnt_s;
    logic            dma_rd_s;
    dmem_cmd_t       cpu_cmd_s;
    dmem_cmd_t       dma_cmd_s;
    dmem_cmd_t       mem_cmd_s;

    // Grant decision and owner next-state.
    always_comb begin
        dma_gnt_s   = 1'b0;
        owner_nxt_s = owner_r;
        case (owner_r)
            S_CPU: begin
                // CPU keeps priority until DMA has been refused STARVE_LIMIT times in a row.
                dma_gnt_s = dma_req & (~cpu_req | (starve_cnt_r == STARVE_TOP));
                if (dma_gnt_s & dma_lock) begin
                    owner_nxt_s = S_DMA;
                end else begin
                    owner_nxt_s = S_CPU;
                end
            end
            S_DMA: begin
                dma_gnt_s = dma_req & (lock_cnt_r < LOCK_TOP);
                if (~dma_req | ~dma_lock | (lock_cnt_r == LOCK_TOP)) begin
                    owner_nxt_s = S_CPU;
                end else begin
                    owner_nxt_s = S_DMA;
                end
            end
            default: begin
                dma_gnt_s   = 1'b0;
                owner_nxt_s = S_CPU;
            end
        endcase
    end

    assign cpu_gnt_s = cpu_req & ~dma_gnt_s;
    assign dma_rd_s  = dma_gnt_s & ~dma_we;

    // Starvation and lock-length counter updates.
    always_comb begin
        starve_nxt_s = {SW{1'b0}};
        lock_nxt_s   = {LW{1'b0}};
        if (dma_req & ~dma_gnt_s) begin
            if (starve_cnt_r == STARVE_TOP) begin
                starve_nxt_s = STARVE_TOP;
            end else begin
                starve_nxt_s = starve_cnt_r + SW'(1);
            end
        end else begin
            starve_nxt_s = {SW{1'b0}};
        end
        // Staying in (or entering) S_DMA always coincides with a DMA grant.
        if (owner_nxt_s == S_DMA) begin
            if (dma_gnt_s) begin
                lock_nxt_s = lock_cnt_r + LW'(1);
            end else begin
                lock_nxt_s = lock_cnt_r;
            end
        end else begin
            lock_nxt_s = {LW{1'b0}};
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r      <= S_CPU;
            starve_cnt_r <= {SW{1'b0}};
            lock_cnt_r   <= {LW{1'b0}};
        end else begin
            owner_r      <= owner_nxt_s;
            starve_cnt_r <= starve_nxt_s;
            lock_cnt_r   <= lock_nxt_s;
        end
    end

    // DMA read return path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dma_rvalid <= 1'b0;
            dma_rdata  <= 32'h0000_0000;
        end else begin
            dma_rvalid <= dma_rd_s;
            if (dma_rd_s) begin
                dma_rdata <= mem_rdata;
            end
        end
    end

    assign cpu_cmd_s = make_cmd(cpu_gnt_s, cpu_we, cpu_w_cs, cpu_r_cs, cpu_addr, cpu_wdata);
    assign dma_cmd_s = make_cmd(dma_gnt_s, dma_we, dma_w_cs, dma_r_cs, dma_addr, dma_wdata);

    dmem_arb_cmd_mux u_cmd_mux (
        .sel_dma (dma_gnt_s),
        .cpu_cmd (cpu_cmd_s),
        .dma_cmd (dma_cmd_s),
        .mem_cmd (mem_cmd_s)
    );

    assign mem_ena   = mem_cmd_s.ena;
    assign mem_wena  = mem_cmd_s.wena;
    assign mem_w_cs  = mem_cmd_s.w_cs;
    assign mem_r_cs  = mem_cmd_s.r_cs;
    assign mem_addr  = mem_cmd_s.addr;
    assign mem_wdata = mem_cmd_s.wdata;
    assign cpu_rdata = mem_rdata;
    assign cpu_stall = cpu_req & dma_gnt_s;
    assign dma_gnt   = dma_gnt_s;

`ifdef DMEM_ARB_STATS_EN
    // Free-running wrap-around usage counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_dma_grants <= 32'h0000_0000;
            stat_cpu_stalls <= 32'h0000_0000;
        end else begin
            if (dma_gnt_s) begin
                stat_dma_grants <= stat_dma_grants + 32'h0000_0001;
            end
            if (cpu_req & dma_gnt_s) begin
                stat_cpu_stalls <= stat_cpu_stalls + 32'h0000_0001;
            end
        end
    end
`endif

endmodule
